// File: rtl/light_display.sv
// Light-level display: converts an 8-bit reading to BCD by shift-add-3 and
// multiplexes it onto a four-digit active-low seven-segment display.
module light_display #(
   parameter int REFRESH_COUNT = 10_000
) (
   input  logic       clk_10Mhz,
   input  logic       reset_n,
   input  logic [7:0] sample_in,
   input  logic       hex_mode,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       busy
);

   localparam int CW = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
   localparam logic [6:0] BLANK   = 7'b1111111;
   localparam logic [6:0] GLYPH_L = 7'b1000111;
   localparam logic [6:0] GLYPH_H = 7'b0001001;

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

   state_t      state, state_next;
   logic [7:0]  captured, captured_next;
   logic [7:0]  work, work_next;
   logic [11:0] bcd, bcd_next, bcd_adj;
   logic [2:0]  iter, iter_next;
   logic [7:0]  last_value;
   logic [3:0]  hundreds, tens, units;
   logic [CW-1:0] refresh_cnt;
   logic [1:0]  digit_idx, digit_next;
   logic [6:0]  seg_next;
   logic        terminal;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   always_comb begin
      state_next    = state;
      captured_next = captured;
      work_next     = work;
      bcd_next      = bcd;
      iter_next     = iter;
      bcd_adj       = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
      case (state)
         S_IDLE: begin
            if (sample_in != last_value) begin
               captured_next = sample_in;
               work_next     = sample_in;
               bcd_next      = '0;
               iter_next     = '0;
               state_next    = S_CONV;
            end
         end
         S_CONV: begin
            {bcd_next, work_next} = {bcd_adj, work} << 1;
            iter_next = iter + 3'd1;
            if (iter == 3'd7) state_next = S_DONE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_10Mhz or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         captured   <= '0;
         work       <= '0;
         bcd        <= '0;
         iter       <= '0;
         last_value <= '0;
         hundreds   <= '0;
         tens       <= '0;
         units      <= '0;
      end else begin
         state    <= state_next;
         captured <= captured_next;
         work     <= work_next;
         bcd      <= bcd_next;
         iter     <= iter_next;
         if (state == S_DONE) begin
            last_value <= captured;
            hundreds   <= bcd[11:8];
            tens       <= bcd[7:4];
            units      <= bcd[3:0];
         end
      end
   end

   // Digit content for the digit about to be lit; leading zeros blank in decimal.
   assign terminal   = (refresh_cnt == CW'(REFRESH_COUNT - 1));
   assign digit_next = digit_idx + 2'd1;

   always_comb begin
      seg_next = BLANK;
      if (hex_mode) begin
         case (digit_next)
            2'd3:    seg_next = GLYPH_H;
            2'd2:    seg_next = BLANK;
            2'd1:    seg_next = glyph(last_value[7:4]);
            default: seg_next = glyph(last_value[3:0]);
         endcase
      end else begin
         case (digit_next)
            2'd3:    seg_next = GLYPH_L;
            2'd2:    seg_next = (hundreds == 4'd0) ? BLANK : glyph(hundreds);
            2'd1:    seg_next = (hundreds == 4'd0 && tens == 4'd0) ? BLANK : glyph(tens);
            default: seg_next = glyph(units);
         endcase
      end
   end

   always_ff @(posedge clk_10Mhz or negedge reset_n) begin
      if (!reset_n) begin
         refresh_cnt <= '0;
         digit_idx   <= 2'd3;
         an          <= 4'b1111;
         seg         <= BLANK;
      end else if (terminal) begin
         refresh_cnt <= '0;
         digit_idx   <= digit_next;
         an          <= ~(4'b0001 << digit_next);
         seg         <= seg_next;
      end else begin
         refresh_cnt <= refresh_cnt + CW'(1);
      end
   end

   assign busy = (state != S_IDLE);
   assign dp   = 1'b1;

endmodule
